bypass_sliced_nd: RTL and testbench

Parametrised multi-stage operand bypass for a bit-sliced physical register file (PRF) read.
- The PRF delivers operand data in `DEPTH` equal slice groups, one group per cycle, lowest group first.
- At every stage the block compares the source tag against all bypass lanes and merges bypass data with PRF groups, so the completed operand appears at the last stage.
- It sits in RegRead, between the PRF read ports and the execute-lane operand latches.
- It adds pipeline stall (hold) and flush, which the fixed two-stage bypass lacks.

---
 rtl/bypass_sliced_nd_pkg.sv | 17 +
 rtl/bypass_sliced_nd_if.sv | 32 +++
 rtl/bypass_sliced_nd_stage_merge.sv | 77 +++++++
 rtl/bypass_sliced_nd.sv | 130 +++++++++++++
 tb/tb_bypass_sliced_nd.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bypass_sliced_nd_pkg.sv
// Shared definitions for the sliced multi-stage operand bypass.
// Bypass lane packet type, default geometry and the derived slice-group width.
package bypass_sliced_nd_pkg;

    localparam int ISSUE_WIDTH       = 4;
    localparam int SIZE_DATA         = 64;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int BYPASS_DEPTH      = 2;
    localparam int BYPASS_GROUP_W    = SIZE_DATA / BYPASS_DEPTH;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
    } bypassPkt;

endpackage

// File: rtl/bypass_sliced_nd_if.sv
// Operand-side bundle of the sliced bypass: bypass lanes, new source, PRF
// slice groups, hold/kill controls and the completed operand.
interface bypass_sliced_nd_if
    import bypass_sliced_nd_pkg::*;
#(
    parameter int DEPTH = BYPASS_DEPTH,
    parameter int LANES = ISSUE_WIDTH
) ();

    localparam int GROUP_W = SIZE_DATA / DEPTH;

    bypassPkt                     bypassPacket_i [0:LANES-1];
    logic                         srcValid_i;
    logic [SIZE_PHYSICAL_LOG-1:0] phySrc_i;
    logic [GROUP_W-1:0]           prfGroup_i [0:DEPTH-1];
    logic                         stall_i;
    logic                         flush_i;
    logic                         valid_o;
    logic [SIZE_PHYSICAL_LOG-1:0] phySrc_o;
    logic [SIZE_DATA-1:0]         data_o;

    modport master (
        output bypassPacket_i, srcValid_i, phySrc_i, prfGroup_i, stall_i, flush_i,
        input  valid_o, phySrc_o, data_o
    );

    modport slave (
        input  bypassPacket_i, srcValid_i, phySrc_i, prfGroup_i, stall_i, flush_i,
        output valid_o, phySrc_o, data_o
    );

endinterface

// File: rtl/bypass_sliced_nd_stage_merge.sv
// One bypass stage: tag compare against all lanes, highest-lane-wins select,
// and per-group merge of bypass, latched and PRF data.
// Optional BYPASS_MULTIMATCH_CHECK_EN adds a multi-hit indication.
module bypass_stage_merge
    import bypass_sliced_nd_pkg::*;
#(
    parameter int STAGE  = 0,
    parameter int LANES  = ISSUE_WIDTH,
    parameter int DATA_W = SIZE_DATA,
    parameter int DEPTH  = BYPASS_DEPTH,
    parameter int TAG_W  = SIZE_PHYSICAL_LOG
) (
    input  bypassPkt                  i_bypass [0:LANES-1],
    input  logic                      i_vld,
    input  logic [TAG_W-1:0]          i_tag,
    input  logic                      i_byp,
    input  logic [DATA_W-1:0]         i_data,
    input  logic [DATA_W/DEPTH-1:0]   i_prf_group,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_byp
`ifdef BYPASS_MULTIMATCH_CHECK_EN
    ,
    output logic                      o_multi
`endif
);

    localparam int GROUP_W = DATA_W / DEPTH;

    logic              w_hit;
    logic [DATA_W-1:0] w_win_data;
`ifdef BYPASS_MULTIMATCH_CHECK_EN
    logic              w_multi;
`endif

    // Scan lanes upward so the highest hitting lane's data is the one kept.
    always_comb begin
        w_hit      = 1'b0;
        w_win_data = '0;
`ifdef BYPASS_MULTIMATCH_CHECK_EN
        w_multi    = 1'b0;
`endif
        for (int l = 0; l < LANES; l++) begin
            if (i_vld && i_bypass[l].valid && (i_bypass[l].tag == i_tag)) begin
`ifdef BYPASS_MULTIMATCH_CHECK_EN
                w_multi = w_multi | w_hit;
`endif
                w_hit      = 1'b1;
                w_win_data = i_bypass[l].data;
            end
        end
    end

    // Group merge: a hit here beats everything since it is the newest producer;
    // groups above this stage are not yet filled and simply pass through.
    always_comb begin
        o_data = i_data;
        for (int g = 0; g < DEPTH; g++) begin
            if (w_hit) begin
                o_data[g*GROUP_W +: GROUP_W] = w_win_data[g*GROUP_W +: GROUP_W];
            end else if (i_byp) begin
                o_data[g*GROUP_W +: GROUP_W] = i_data[g*GROUP_W +: GROUP_W];
            end else if (g < STAGE) begin
                o_data[g*GROUP_W +: GROUP_W] = i_data[g*GROUP_W +: GROUP_W];
            end else if (g == STAGE) begin
                o_data[g*GROUP_W +: GROUP_W] = i_prf_group;
            end else begin
                o_data[g*GROUP_W +: GROUP_W] = i_data[g*GROUP_W +: GROUP_W];
            end
        end
    end

    assign o_byp = i_byp | w_hit;
`ifdef BYPASS_MULTIMATCH_CHECK_EN
    assign o_multi = w_multi;
`endif

endmodule

// File: rtl/bypass_sliced_nd.sv
// Multi-stage operand bypass for a bit-sliced PRF read, with hold and flush.
// Stage s sees PRF slice group s; the last stage is combinational and drives
// the completed operand. DATA_W/TAG_W must match the bypassPkt field widths.
// Optional feature macro: BYPASS_MULTIMATCH_CHECK_EN (adds sticky multiMatch_o).
module bypass_sliced_nd
    import bypass_sliced_nd_pkg::*;
#(
    parameter int DEPTH  = BYPASS_DEPTH,
    parameter int LANES  = ISSUE_WIDTH,
    parameter int DATA_W = SIZE_DATA,
    parameter int TAG_W  = SIZE_PHYSICAL_LOG
) (
    input  logic                 clk,
    input  logic                 reset,
    bypass_sliced_nd_if.slave    bus
`ifdef BYPASS_MULTIMATCH_CHECK_EN
    ,
    output logic                 multiMatch_o
`endif
);

    localparam int NREG = (DEPTH > 1) ? DEPTH - 1 : 1;

    // Register k feeds stage k+1.
    logic              r_vld  [0:NREG-1];
    logic [TAG_W-1:0]  r_tag  [0:NREG-1];
    logic              r_byp  [0:NREG-1];
    logic [DATA_W-1:0] r_data [0:NREG-1];

    logic              w_stg_vld  [0:DEPTH-1];
    logic [TAG_W-1:0]  w_stg_tag  [0:DEPTH-1];
    logic              w_stg_byp  [0:DEPTH-1];
    logic [DATA_W-1:0] w_stg_data [0:DEPTH-1];
    logic [DATA_W-1:0] w_mrg_data [0:DEPTH-1];
    logic              w_mrg_byp  [0:DEPTH-1];
`ifdef BYPASS_MULTIMATCH_CHECK_EN
    logic              w_mrg_multi [0:DEPTH-1];
`endif

    assign w_stg_vld[0]  = bus.srcValid_i;
    assign w_stg_tag[0]  = bus.phySrc_i;
    assign w_stg_byp[0]  = 1'b0;
    assign w_stg_data[0] = '0;

    for (genvar s = 1; s < DEPTH; s++) begin : g_stage_in
        assign w_stg_vld[s]  = r_vld[s-1];
        assign w_stg_tag[s]  = r_tag[s-1];
        assign w_stg_byp[s]  = r_byp[s-1];
        assign w_stg_data[s] = r_data[s-1];
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_merge
        bypass_stage_merge #(
            .STAGE  (s),
            .LANES  (LANES),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .TAG_W  (TAG_W)
        ) u_merge (
            .i_bypass    (bus.bypassPacket_i),
            .i_vld       (w_stg_vld[s]),
            .i_tag       (w_stg_tag[s]),
            .i_byp       (w_stg_byp[s]),
            .i_data      (w_stg_data[s]),
            .i_prf_group (bus.prfGroup_i[s]),
            .o_data      (w_mrg_data[s]),
            .o_byp       (w_mrg_byp[s])
`ifdef BYPASS_MULTIMATCH_CHECK_EN
            ,
            .o_multi     (w_mrg_multi[s])
`endif
        );
    end

    if (DEPTH > 1) begin : g_regs
        // Inter-stage registers: advance normally; on stall, each held stage
        // writes back its own merge so a broadcast during the hold is kept.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    r_vld[k]  <= 1'b0;
                    r_tag[k]  <= '0;
                    r_byp[k]  <= 1'b0;
                    r_data[k] <= '0;
                end
            end else if (bus.flush_i) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    r_vld[k] <= 1'b0;
                end
            end else if (bus.stall_i) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    r_byp[k]  <= w_mrg_byp[k+1];
                    r_data[k] <= w_mrg_data[k+1];
                end
            end else begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    r_vld[k]  <= w_stg_vld[k];
                    r_tag[k]  <= w_stg_tag[k];
                    r_byp[k]  <= w_mrg_byp[k];
                    r_data[k] <= w_mrg_data[k];
                end
            end
        end
    end

    // Flush and reset kill the output in the same cycle they are seen.
    assign bus.valid_o  = w_stg_vld[DEPTH-1] & ~bus.flush_i & ~reset;
    assign bus.phySrc_o = w_stg_tag[DEPTH-1];
    assign bus.data_o   = w_mrg_data[DEPTH-1];

`ifdef BYPASS_MULTIMATCH_CHECK_EN
    logic r_multi;

    // Sticky multi-hit flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_multi <= 1'b0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (w_mrg_multi[s]) begin
                    r_multi <= 1'b1;
                end
            end
        end
    end

    assign multiMatch_o = r_multi;
`endif

endmodule

// File: tb/tb_bypass_sliced_nd.sv
// Scoreboard bench for bypass_sliced_nd at DEPTH=2, DATA_W=64, LANES=4.
module tb_bypass_sliced_nd;
    import bypass_sliced_nd_pkg::*;

    typedef struct {
        logic [6:0]  tag;
        logic [63:0] data;
    } exp_t;

    logic clk;
    logic reset;
`ifdef BYPASS_MULTIMATCH_CHECK_EN
    logic multiMatch_o;
`endif

    int   n_vec;
    int   n_err;
    exp_t exp_q [$];

    bypass_sliced_nd_if #(.DEPTH(2), .LANES(4)) bus ();

    bypass_sliced_nd #(.DEPTH(2), .LANES(4), .DATA_W(64), .TAG_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef BYPASS_MULTIMATCH_CHECK_EN
        ,
        .multiMatch_o (multiMatch_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_byp();
        for (int l = 0; l < 4; l++) bus.bypassPacket_i[l] = '0;
    endtask

    task automatic set_byp(input int l, input logic [6:0] t, input logic [63:0] d);
        bus.bypassPacket_i[l] = '{valid: 1'b1, tag: t, data: d};
    endtask

    task automatic idle();
        clr_byp();
        bus.srcValid_i    = 1'b0;
        bus.phySrc_i      = '0;
        bus.prfGroup_i[0] = '0;
        bus.prfGroup_i[1] = '0;
        bus.stall_i       = 1'b0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic issue(input logic [6:0] t, input logic [31:0] g0);
        bus.srcValid_i    = 1'b1;
        bus.phySrc_i      = t;
        bus.prfGroup_i[0] = g0;
    endtask

    // Monitor: an entry leaves the last stage when valid and not held.
    always @(negedge clk) begin
        if (!reset && bus.valid_o && !bus.stall_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got tag %0d data %h expected no output",
                         bus.phySrc_o, bus.data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({bus.phySrc_o, bus.data_o} !== {e.tag, e.data}) begin
                    n_err++;
                    $display("FAIL operand: got tag %0d data %h expected tag %0d data %h",
                             bus.phySrc_o, bus.data_o, e.tag, e.data);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        bus.srcValid_i = 1'b1;
        bus.phySrc_i   = 7'd3;
        step();
        step();
        @(negedge clk);
        chk("reset_valid", 72'(bus.valid_o), 72'd0);
`ifdef BYPASS_MULTIMATCH_CHECK_EN
        chk("reset_multi", 72'(multiMatch_o), 72'd0);
`endif
        step();
        idle();
        reset = 1'b0;
        step();

        // plain PRF read
        issue(7'd5, 32'h11111111);
        exp_q.push_back('{tag: 7'd5, data: 64'h2222222211111111});
        step();
        idle();
        bus.prfGroup_i[1] = 32'h22222222;
        step();

        // stage-0 bypass on lane 2 overrides PRF group 1
        issue(7'd5, 32'h11111111);
        set_byp(2, 7'd5, 64'hAAAABBBBCCCCDDDD);
        exp_q.push_back('{tag: 7'd5, data: 64'hAAAABBBBCCCCDDDD});
        step();
        idle();
        bus.prfGroup_i[1] = 32'h22222222;
        step();

        // stage-1 hit on lane 0 overrides earlier stage-0 hit on lane 3
        issue(7'd6, 32'h11111111);
        set_byp(3, 7'd6, 64'hFFFF0000FFFF0000);
        exp_q.push_back('{tag: 7'd6, data: 64'h1234567890ABCDEF});
        step();
        idle();
        set_byp(0, 7'd6, 64'h1234567890ABCDEF);
        bus.prfGroup_i[1] = 32'h22222222;
        step();
        idle();

        // two lanes hit, highest lane wins
        issue(7'd7, 32'h11111111);
        set_byp(1, 7'd7, 64'd1);
        set_byp(3, 7'd7, 64'd3);
        exp_q.push_back('{tag: 7'd7, data: 64'd3});
        step();
        idle();
        bus.prfGroup_i[1] = 32'h22222222;
        step();
        idle();
`ifdef BYPASS_MULTIMATCH_CHECK_EN
        step();
        @(negedge clk);
        chk("multi_sticky", 72'(multiMatch_o), 72'd1);
`endif

        // back-to-back operands
        issue(7'd10, 32'hA0A0A0A0);
        exp_q.push_back('{tag: 7'd10, data: 64'hA1A1A1A1A0A0A0A0});
        step();
        issue(7'd11, 32'hB0B0B0B0);
        bus.prfGroup_i[1] = 32'hA1A1A1A1;
        exp_q.push_back('{tag: 7'd11, data: 64'hB1B1B1B1B0B0B0B0});
        step();
        idle();
        bus.prfGroup_i[1] = 32'hB1B1B1B1;
        step();
        idle();

        // stall 3 cycles with entry in stage 1; broadcast in stall cycle 2
        issue(7'd9, 32'h00000033);
        exp_q.push_back('{tag: 7'd9, data: 64'h55});
        step();
        idle();
        bus.stall_i       = 1'b1;
        bus.prfGroup_i[0] = 32'h00000033;
        bus.prfGroup_i[1] = 32'h00000044;
        @(negedge clk);
        chk("stall1_data", 72'(bus.data_o), 72'h0000004400000033);
        step();
        set_byp(0, 7'd9, 64'h55);
        step();
        clr_byp();
        @(negedge clk);
        chk("stall3_data", 72'(bus.data_o), 72'h55);
        chk("stall3_valid", 72'(bus.valid_o), 72'd1);
        step();
        bus.stall_i = 1'b0;
        step();
        idle();

        // flush with both stages valid
        issue(7'd12, 32'h000000C0);
        step();
        issue(7'd13, 32'h000000D0);
        bus.prfGroup_i[1] = 32'h000000C1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_valid", 72'(bus.valid_o), 72'd0);
        step();
        idle();
        @(negedge clk);
        chk("post_flush_valid", 72'(bus.valid_o), 72'd0);
        step();
        issue(7'd14, 32'h000000E0);
        exp_q.push_back('{tag: 7'd14, data: 64'h000000E1000000E0});
        step();
        idle();
        bus.prfGroup_i[1] = 32'h000000E1;
        step();
        idle();

        // reset mid-operation discards the entry
        issue(7'd15, 32'h000000F0);
        step();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_valid", 72'(bus.valid_o), 72'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 72'(bus.valid_o), 72'd0);
`ifdef BYPASS_MULTIMATCH_CHECK_EN
        chk("multi_cleared", 72'(multiMatch_o), 72'd0);
`endif
        step();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("drain_pending", 72'(exp_q.size()), 72'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
